alu_issue_ctrl: RTL and testbench

Initiator side of the 32b ALU interface. Accepts decoded-operand MIPS instructions over a valid/ready handshake and maps opcode/funct/shamt to the 11b op_ctl bus. It forms the A/B operands (immediate extension, shift-operand swap), drives the combinational ALU from a registered issue stage, and captures result plus flags into a registered response stage with backpressure. It sits between the register-read stage and writeback.

---
 rtl/alu_issue_ctrl_if.sv | 50 +++++
 rtl/alu_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response bundle between register-read, the ALU and writeback.
// The master modport is the issue controller; the slave modport is its environment.
interface alu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_opcode;
    logic [5:0]       in_funct;
    logic [4:0]       in_shamt;
    logic [31:0]      in_rs_val;
    logic [31:0]      in_rt_val;
    logic [15:0]      in_imm;
    logic [TAG_W-1:0] in_tag;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [10:0]      alu_op_ctl;
    logic [31:0]      alu_z;
    logic             alu_overflow;
    logic             alu_zero;
    logic             alu_carryout;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_zero;
    logic             out_carry;
    logic             out_ovf_exc;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        input  in_valid, in_opcode, in_funct, in_shamt, in_rs_val, in_rt_val, in_imm, in_tag,
        output in_ready,
        output alu_a, alu_b, alu_op_ctl,
        input  alu_z, alu_overflow, alu_zero, alu_carryout,
        output out_valid, out_result, out_zero, out_carry, out_ovf_exc, out_illegal, out_tag,
        input  out_ready
    );

    modport slave (
        output in_valid, in_opcode, in_funct, in_shamt, in_rs_val, in_rt_val, in_imm, in_tag,
        input  in_ready,
        input  alu_a, alu_b, alu_op_ctl,
        output alu_z, alu_overflow, alu_zero, alu_carryout,
        input  out_valid, out_result, out_zero, out_carry, out_ovf_exc, out_illegal, out_tag,
        output out_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// MIPS ALU issue controller: decode -> S1 issue register -> ALU -> S2 response register.
// Latency 2 edges accept-to-response; out_ready low holds S2, then S1, then drops in_ready.
module alu_issue_ctrl #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.master bus
);
    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [10:0]      op_ctl;
        logic             ovf_en;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic [31:0]      result;
        logic             zero;
        logic             carry;
        logic             ovf_exc;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } s2_t;

    s1_t         dec;
    s1_t         s1;
    logic        s1_valid;
    s2_t         s2;
    logic        s2_load;
    logic        in_fire;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign s2_load      = !s2.valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_load;
    assign in_fire      = bus.in_valid && bus.in_ready;

    assign imm_sext = {{16{bus.in_imm[15]}}, bus.in_imm};
    assign imm_zext = {16'h0000, bus.in_imm};

    // Anything not explicitly decoded falls through as an illegal op issuing 0+0.
    always_comb begin
        dec         = '0;
        dec.tag     = bus.in_tag;
        dec.op_ctl  = {5'd0, 6'h20};
        dec.illegal = 1'b0;
        case (bus.in_opcode)
            6'h00: begin
                case (bus.in_funct)
                    6'h00, 6'h02: begin
                        dec.a      = bus.in_rt_val;
                        dec.op_ctl = {bus.in_shamt, bus.in_funct};
                    end
                    6'h04, 6'h06: begin
                        dec.a      = bus.in_rt_val;
                        dec.op_ctl = {bus.in_rs_val[4:0], bus.in_funct};
                    end
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        dec.a      = bus.in_rs_val;
                        dec.b      = bus.in_rt_val;
                        dec.op_ctl = {5'd0, bus.in_funct};
                        dec.ovf_en = (bus.in_funct == 6'h20) || (bus.in_funct == 6'h22);
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'h08: begin
                dec.a      = bus.in_rs_val;
                dec.b      = imm_sext;
                dec.op_ctl = {5'd0, 6'h20};
                dec.ovf_en = 1'b1;
            end
            6'h09: begin
                dec.a      = bus.in_rs_val;
                dec.b      = imm_sext;
                dec.op_ctl = {5'd0, 6'h21};
            end
            6'h0A: begin
                dec.a      = bus.in_rs_val;
                dec.b      = imm_sext;
                dec.op_ctl = {5'd0, 6'h2A};
            end
            6'h0B: begin
                dec.a      = bus.in_rs_val;
                dec.b      = imm_sext;
                dec.op_ctl = {5'd0, 6'h2B};
            end
            6'h0C: begin
                dec.a      = bus.in_rs_val;
                dec.b      = imm_zext;
                dec.op_ctl = {5'd0, 6'h24};
            end
            6'h0D: begin
                dec.a      = bus.in_rs_val;
                dec.b      = imm_zext;
                dec.op_ctl = {5'd0, 6'h25};
            end
            6'h0E: begin
                dec.a      = bus.in_rs_val;
                dec.b      = imm_zext;
                dec.op_ctl = {5'd0, 6'h26};
            end
            6'h0F: begin
                // LUI reuses the shifter: imm shifted left by 16.
                dec.a      = imm_zext;
                dec.op_ctl = {5'd16, 6'h00};
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
            s2       <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1       <= dec;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2.valid <= s1_valid;
                if (s1_valid) begin
                    s2.result  <= s1.illegal ? 32'h0 : bus.alu_z;
                    s2.zero    <= !s1.illegal && bus.alu_zero;
                    s2.carry   <= !s1.illegal && bus.alu_carryout;
                    s2.ovf_exc <= s1.ovf_en && bus.alu_overflow;
                    s2.illegal <= s1.illegal;
                    s2.tag     <= s1.tag;
                end
            end
        end
    end

    assign bus.alu_a       = s1.a;
    assign bus.alu_b       = s1.b;
    assign bus.alu_op_ctl  = s1.op_ctl;

    assign bus.out_valid   = s2.valid;
    assign bus.out_result  = s2.result;
    assign bus.out_zero    = s2.zero;
    assign bus.out_carry   = s2.carry;
    assign bus.out_ovf_exc = s2.ovf_exc;
    assign bus.out_illegal = s2.illegal;
    assign bus.out_tag     = s2.tag;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a response scoreboard.
module tb_alu_issue_ctrl;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [31:0]      res;
        logic             zero;
        logic             chk_carry;
        logic             carry;
        logic             ovf;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   resp_cnt = 0;
    logic [TAG_W-1:0] tag_ctr = '0;
    exp_t sb[$];

    alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    alu_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU following the op_ctl encoding.
    logic [31:0] m_z;
    logic [31:0] m_bb;
    logic [32:0] m_sum;
    logic        m_ovf;
    logic        m_co;
    logic [5:0]  m_c;
    logic [4:0]  m_sh;

    always_comb begin
        m_z   = '0;
        m_bb  = '0;
        m_sum = '0;
        m_ovf = 1'b0;
        m_co  = 1'b0;
        m_c   = bus.alu_op_ctl[5:0];
        m_sh  = bus.alu_op_ctl[10:6];
        if (!m_c[5]) begin
            m_z = m_c[1] ? (bus.alu_a >> m_sh) : (bus.alu_a << m_sh);
        end else if (m_c[2]) begin
            case (m_c[1:0])
                2'd0:    m_z = bus.alu_a & bus.alu_b;
                2'd1:    m_z = bus.alu_a | bus.alu_b;
                2'd2:    m_z = bus.alu_a ^ bus.alu_b;
                default: m_z = ~(bus.alu_a | bus.alu_b);
            endcase
        end else if (m_c[3]) begin
            if (m_c[0]) m_z = {31'b0, bus.alu_a < bus.alu_b};
            else        m_z = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
        end else begin
            m_bb  = m_c[1] ? ~bus.alu_b : bus.alu_b;
            m_sum = {1'b0, bus.alu_a} + {1'b0, m_bb} + {32'b0, m_c[1]};
            m_z   = m_sum[31:0];
            m_co  = m_sum[32];
            m_ovf = (bus.alu_a[31] == m_bb[31]) && (m_z[31] != bus.alu_a[31]);
        end
    end

    assign bus.alu_z        = m_z;
    assign bus.alu_overflow = m_ovf;
    assign bus.alu_carryout = m_co;
    assign bus.alu_zero     = (m_z == 32'h0);

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    // Instruction-level reference: what writeback should see for each MIPS op.
    function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] sh, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [15:0] imm);
        exp_t        r;
        logic [31:0] se;
        logic [31:0] ze;
        logic [32:0] w;
        r  = '0;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0, imm};
        w  = '0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h00: r.res = rt << sh;
                    6'h02: r.res = rt >> sh;
                    6'h04: r.res = rt << rs[4:0];
                    6'h06: r.res = rt >> rs[4:0];
                    6'h20, 6'h21: begin
                        w = {1'b0, rs} + {1'b0, rt};
                        r.res = w[31:0]; r.chk_carry = 1'b1; r.carry = w[32];
                        r.ovf = (fn == 6'h20) && (rs[31] == rt[31]) && (r.res[31] != rs[31]);
                    end
                    6'h22, 6'h23: begin
                        w = {1'b0, rs} + {1'b0, ~rt} + 33'd1;
                        r.res = w[31:0]; r.chk_carry = 1'b1; r.carry = w[32];
                        r.ovf = (fn == 6'h22) && (rs[31] != rt[31]) && (r.res[31] != rs[31]);
                    end
                    6'h24: r.res = rs & rt;
                    6'h25: r.res = rs | rt;
                    6'h26: r.res = rs ^ rt;
                    6'h27: r.res = ~(rs | rt);
                    6'h2A: r.res = {31'b0, $signed(rs) < $signed(rt)};
                    6'h2B: r.res = {31'b0, rs < rt};
                    default: r.ill = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin
                w = {1'b0, rs} + {1'b0, se};
                r.res = w[31:0]; r.chk_carry = 1'b1; r.carry = w[32];
                r.ovf = (op == 6'h08) && (rs[31] == se[31]) && (r.res[31] != rs[31]);
            end
            6'h0A: r.res = {31'b0, $signed(rs) < $signed(se)};
            6'h0B: r.res = {31'b0, rs < se};
            6'h0C: r.res = rs & ze;
            6'h0D: r.res = rs | ze;
            6'h0E: r.res = rs ^ ze;
            6'h0F: r.res = {imm, 16'h0};
            default: r.ill = 1'b1;
        endcase
        if (r.ill) begin
            r.chk_carry = 1'b1;
            r.carry     = 1'b0;
        end
        r.zero = !r.ill && (r.res == 32'h0);
        return r;
    endfunction

    // Response monitor: a handshake seen here completes at the following posedge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            resp_cnt++;
            check("resp_expected", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("out_tag",     {28'b0, bus.out_tag},     {28'b0, e.tag});
                check("out_result",  bus.out_result,           e.res);
                check("out_illegal", {31'b0, bus.out_illegal}, {31'b0, e.ill});
                check("out_ovf_exc", {31'b0, bus.out_ovf_exc}, {31'b0, e.ovf});
                check("out_zero",    {31'b0, bus.out_zero},    {31'b0, e.zero});
                if (e.chk_carry)
                    check("out_carry", {31'b0, bus.out_carry}, {31'b0, e.carry});
            end
        end
    end

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
        bus.in_opcode = op;
        bus.in_funct  = fn;
        bus.in_shamt  = sh;
        bus.in_rs_val = rs;
        bus.in_rt_val = rt;
        bus.in_imm    = imm;
        bus.in_tag    = tag_ctr;
        bus.in_valid  = 1'b1;
    endtask

    task automatic wait_accept();
        exp_t e;
        int   n;
        e = ref_model(bus.in_opcode, bus.in_funct, bus.in_shamt,
                      bus.in_rs_val, bus.in_rt_val, bus.in_imm);
        e.tag = bus.in_tag;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("in_ready_wait", {31'b0, bus.in_ready}, 32'd1);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        tag_ctr++;
    endtask

    task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
        drive(op, fn, sh, rs, rt, imm);
        wait_accept();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0]      snap_res;
        logic [TAG_W-1:0] snap_tag;
        logic [TAG_W-1:0] tag_a;
        logic [TAG_W-1:0] tag_b;
        int               saved_cnt;
        int               n;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_funct  = '0;
        bus.in_shamt  = '0;
        bus.in_rs_val = '0;
        bus.in_rt_val = '0;
        bus.in_imm    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   {31'b0, bus.in_ready},    32'd1);
        check("rst_out_valid",  {31'b0, bus.out_valid},   32'd0);
        check("rst_alu_a",      bus.alu_a,                32'd0);
        check("rst_alu_b",      bus.alu_b,                32'd0);
        check("rst_alu_op_ctl", {21'b0, bus.alu_op_ctl},  32'd0);
        check("rst_out_result", bus.out_result,           32'd0);
        check("rst_out_flags",  {28'b0, bus.out_zero, bus.out_carry, bus.out_ovf_exc, bus.out_illegal}, 32'd0);
        check("rst_out_tag",    {28'b0, bus.out_tag},     32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Arithmetic, compare, logic and immediates.
        send(6'h00, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0);
        send(6'h00, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0);
        send(6'h00, 6'h2B, 5'd0, 32'h0000_0001, 32'hFFFF_FFFF, 16'h0);
        send(6'h00, 6'h2A, 5'd0, 32'h0000_0001, 32'hFFFF_FFFF, 16'h0);
        send(6'h00, 6'h06, 5'd0, 32'h0000_0004, 32'h0000_00F0, 16'h0);
        send(6'h0F, 6'h00, 5'd0, 32'h1234_5678, 32'h0,         16'hBEEF);
        send(6'h0C, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h0,         16'h8001);
        send(6'h09, 6'h00, 5'd0, 32'h0000_0000, 32'h0,         16'hFFFF);
        send(6'h08, 6'h00, 5'd0, 32'h7FFF_FFF0, 32'h0,         16'h0010);
        send(6'h00, 6'h27, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F, 16'h0);
        send(6'h00, 6'h03, 5'd3, 32'h1,         32'h8000_0000, 16'h0);
        send(6'h3F, 6'h20, 5'd0, 32'h5,         32'h5,         16'h0);
        idle(4);

        // Issue-stage op_ctl and two-edge latency from an idle pipeline.
        send(6'h00, 6'h22, 5'd0, 32'd5, 32'd5, 16'h0);
        @(negedge clk);
        check("sub_op_ctl", {21'b0, bus.alu_op_ctl}, 32'h022);
        check("lat_s1_only", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        check("lat_resp", {31'b0, bus.out_valid}, 32'd1);
        idle(3);
        send(6'h00, 6'h00, 5'd31, 32'h0, 32'h1, 16'h0);
        @(negedge clk);
        check("sll_op_ctl", {21'b0, bus.alu_op_ctl}, 32'h7C0);
        idle(4);

        // Ten back-to-back requests, tags 0..9.
        tag_ctr  = '0;
        resp_cnt = 0;
        for (int i = 0; i < 10; i++)
            send(6'h00, 6'h21, 5'd0, 32'(i * 3), 32'(i + 100), 16'h0);
        check("burst_cnt_e9", resp_cnt, 32'd8);
        idle(1);
        check("burst_cnt_e10", resp_cnt, 32'd9);
        idle(1);
        check("burst_cnt_e11", resp_cnt, 32'd10);
        idle(3);

        // Backpressure: both stages fill, outputs hold, then dual accept.
        bus.out_ready = 1'b0;
        tag_a = tag_ctr;
        send(6'h00, 6'h26, 5'd0, 32'hAAAA_0000, 32'h0000_5555, 16'h0);
        tag_b = tag_ctr;
        send(6'h0D, 6'h00, 5'd0, 32'h1000_0000, 32'h0,         16'h00FF);
        drive(6'h00, 6'h23, 5'd0, 32'h3, 32'h7, 16'h0);
        @(negedge clk);
        check("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        check("bp_head_tag", {28'b0, bus.out_tag}, {28'b0, tag_a});
        snap_res = bus.out_result;
        snap_tag = bus.out_tag;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_hold_valid",  {31'b0, bus.out_valid}, 32'd1);
        check("bp_hold_result", bus.out_result, snap_res);
        check("bp_hold_tag",    {28'b0, bus.out_tag}, {28'b0, snap_tag});
        check("bp_still_full",  {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_accept();
        check("dual_accept_tag",   {28'b0, bus.out_tag}, {28'b0, tag_b});
        check("dual_accept_valid", {31'b0, bus.out_valid}, 32'd1);
        idle(4);

        // Reset with two requests in flight.
        bus.out_ready = 1'b0;
        send(6'h00, 6'h24, 5'd0, 32'hFF, 32'h0F, 16'h0);
        send(6'h00, 6'h25, 5'd0, 32'hF0, 32'h0F, 16'h0);
        rst = 1'b1;
        sb.delete();
        saved_cnt = resp_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_mid_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("rst_mid_op_ctl",    {21'b0, bus.alu_op_ctl}, 32'd0);
        bus.out_ready = 1'b1;
        idle(5);
        check("no_stale_resp", resp_cnt, saved_cnt);

        // Pipeline still functional after the mid-flight reset.
        send(6'h0F, 6'h00, 5'd0, 32'h0, 32'h0, 16'h1234);
        send(6'h0A, 6'h00, 5'd0, 32'hFFFF_FFFE, 32'h0, 16'hFFFF);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("drain_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
